um2cdp_transmit: RTL and testbench
==================================

UM2CDP_TRANSMIT -- requirements
Module: um2cdp_transmit

Interface
REQ-001 The block SHALL have: clk  input  1  clock; all logic on the rising edge.
REQ-002 The block SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have: pkt_valid  input  1  pkt carries a valid word this cycle.
REQ-004 The block SHALL have: pkt  input  139  packet word; [138:136] tag: 3'b101 head, 3'b100 middle, 3'b110 tail; [127:0] payload.
REQ-005 The block SHALL have: transmit_usedw  output  8  buffer occupancy in words, for upstream flow control.
REQ-006 The block SHALL have: cdp2um_tx_enable  input  1  CDP may accept a new packet; sampled only at packet start.
REQ-007 The block SHALL have: um2cdp_data_valid  output  1  um2cdp_data is valid this cycle.
REQ-008 The block SHALL have: um2cdp_data  output  139  word to CDP, same tag encoding as pkt.
REQ-009 The block SHALL have: drop_cnt  output  16  count of packets dropped on input, saturating at 16'hFFFF.
REQ-010 The block SHALL have: parameter ACCEPT_MAX, default 8'd127, meaning the highest transmit_usedw at which a head word is accepted.

Function
REQ-011 Input FSM states SHALL be IN_IDLE, IN_STORE and IN_DROP.
REQ-012 In IN_IDLE, on pkt_valid with a head tag and transmit_usedw <= ACCEPT_MAX, the block SHALL write the word and go to IN_STORE.
REQ-013 In IN_IDLE, on a head tag with transmit_usedw > ACCEPT_MAX, the block SHALL not write, SHALL increment drop_cnt, and SHALL go to IN_DROP.
REQ-014 In IN_IDLE, non-head words SHALL be discarded silently, with no drop_cnt change.
REQ-015 In IN_STORE, every pkt_valid word SHALL be written; a tail word SHALL return the FSM to IN_IDLE.
REQ-016 In IN_DROP, words SHALL be discarded until the tail word, then the FSM SHALL return to IN_IDLE.
REQ-017 In IN_STORE, a second head word (missing tail) SHALL be written with its tag forced to 3'b110, and the FSM SHALL go to IN_IDLE.
REQ-018 pkt_cnt (8 bit) SHALL count complete buffered packets: +1 when a tail is written, -1 when a tail is read, unchanged when both happen in the same cycle.
REQ-019 Output FSM states SHALL be OUT_IDLE and OUT_SEND.
REQ-020 In OUT_IDLE, when pkt_cnt != 0 and cdp2um_tx_enable = 1, the block SHALL issue a buffer read and go to OUT_SEND.
REQ-021 In OUT_SEND, the block SHALL read one word every cycle with no gaps; after the read of the tail word it SHALL go to OUT_IDLE.
REQ-022 Deassertion of cdp2um_tx_enable during OUT_SEND SHALL NOT stall the packet in progress.
REQ-023 Latency SHALL be: read issued in cycle N, so um2cdp_data_valid = 1 with the word in cycle N+1, registered.
REQ-024 um2cdp_data SHALL hold its last value when um2cdp_data_valid = 0.
REQ-025 Back-to-back packets SHALL be separated by exactly one idle cycle, the OUT_IDLE re-evaluation.
REQ-026 Minimum latency from input tail write to output head SHALL be 3 cycles, with cdp2um_tx_enable = 1.
REQ-027 Writes and reads SHALL proceed in the same cycle; transmit_usedw SHALL reflect net occupancy the cycle after.
REQ-028 A write attempted while the buffer is full (occupancy 256) SHALL be dropped, and the packet SHALL be truncated with a forced tail on the next accepted word; with ACCEPT_MAX at its default and packets of 128 words or fewer, this SHALL never occur.

Reset
REQ-029 On reset low, the block SHALL asynchronously clear: both FSMs to idle, pkt_cnt = 0, drop_cnt = 0, um2cdp_data_valid = 0, um2cdp_data = 0, transmit_usedw = 0, and buffer pointers = 0.
REQ-030 Reset asserted mid-packet SHALL discard all buffered content; after release, the first accepted word SHALL be a head.

Structure
REQ-031 Tag constants (TAG_HEAD, TAG_MID, TAG_TAIL), word width 139 and buffer depth 256 SHALL live in the shared UM package.
REQ-032 Buffering SHALL use one sub-module, um_sync_fifo: 256x139, registered read, 1-cycle read latency, 8-bit usedw plus a full flag.
REQ-033 Both FSMs, pkt_cnt and drop_cnt SHALL reside in um2cdp_transmit.

Verification
REQ-034 A 4-word packet (101,100,100,110) with tx_enable = 1 SHALL appear on um2cdp_data unchanged, contiguous, starting 3 cycles after the tail input; drop_cnt = 0.
REQ-035 Two 4-word packets input back-to-back with tx_enable = 1 SHALL be output as 4 words, 1 idle cycle, then 4 words.
REQ-036 With tx_enable = 0, 3 packets buffered (pkt_cnt = 3); raising tx_enable then dropping it after 1 cycle SHALL send exactly one full packet.
REQ-037 With tx_enable held at 0, filling to usedw = 128 then sending a head SHALL drop the whole packet (drop_cnt = 1, usedw stays 128), and the next packet sent after draining SHALL be accepted.
REQ-038 A head, middle, then a new head with no tail SHALL output the first packet as 101,100,110, and the second packet SHALL be discarded.
REQ-039 Reset pulsed during output of word 2 of 6 SHALL give um2cdp_data_valid = 0 next cycle and usedw = 0, and a fresh packet afterward SHALL be sent intact.

Source files
------------

// File: rtl/um2cdp_transmit_pkg.sv
// Shared UM definitions: packet word layout, tag encodings, buffer geometry and FSM state types.
// Pure declarations; no latency or flow-control behaviour of its own.
package um2cdp_transmit_pkg;

    localparam int WORD_W     = 139;
    localparam int FIFO_DEPTH = 256;
    localparam int ADDR_W     = 8;

    localparam logic [2:0] TAG_HEAD = 3'b101;
    localparam logic [2:0] TAG_MID  = 3'b100;
    localparam logic [2:0] TAG_TAIL = 3'b110;

    typedef struct packed {
        logic [2:0]   tag;
        logic [7:0]   rsvd;
        logic [127:0] payload;
    } pkt_word_t;

    typedef enum logic [1:0] {IN_IDLE, IN_STORE, IN_DROP} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

    function automatic logic is_tail(input pkt_word_t w);
        return w.tag == TAG_TAIL;
    endfunction

endpackage

// File: rtl/um2cdp_transmit_if.sv
// Packet-in / CDP-out bundle of um2cdp_transmit; slave is the transmit block, master the UM/CDP side.
// No latency; upstream throttles itself from transmit_usedw, CDP gates packet starts with cdp2um_tx_enable.
interface um2cdp_transmit_if;
    import um2cdp_transmit_pkg::*;

    logic       pkt_valid;
    pkt_word_t  pkt;
    logic [7:0] transmit_usedw;
    logic       cdp2um_tx_enable;
    logic       um2cdp_data_valid;
    pkt_word_t  um2cdp_data;
    logic [15:0] drop_cnt;

    modport slave (
        input  pkt_valid, pkt, cdp2um_tx_enable,
        output transmit_usedw, um2cdp_data_valid, um2cdp_data, drop_cnt
    );

    modport master (
        output pkt_valid, pkt, cdp2um_tx_enable,
        input  transmit_usedw, um2cdp_data_valid, um2cdp_data, drop_cnt
    );

endinterface

// File: rtl/um_sync_fifo.sv
// 256x139 synchronous FIFO, registered read (data one cycle after rd_en), 8-bit usedw plus full.
// Writes while full and reads while empty are ignored; rd_mark peeks the sideband bit of the next word to read.
module um_sync_fifo
    import um2cdp_transmit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  pkt_word_t         wr_dat,
    input  logic              wr_mark,
    input  logic              rd_en,
    output pkt_word_t         rd_dat,
    output logic              rd_mark,
    output logic [ADDR_W-1:0] usedw,
    output logic              full
);

    logic [WORD_W-1:0]     mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mark_bits;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       cnt;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = cnt[ADDR_W];
    assign usedw   = cnt[ADDR_W-1:0];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && (cnt != '0);
    assign rd_mark = mark_bits[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr]       <= wr_dat;
            mark_bits[wr_ptr] <= wr_mark;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rd_dat <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_dat <= pkt_word_t'(mem[rd_ptr]);
            end
            if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
            else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/um2cdp_transmit.sv
// Buffers whole UM packets and forwards them to CDP; tail in to head out is 3 cycles, words leave back to back.
// Heads above ACCEPT_MAX occupancy drop their packet; cdp2um_tx_enable only gates packet starts.
module um2cdp_transmit
    import um2cdp_transmit_pkg::*;
#(
    parameter logic [7:0] ACCEPT_MAX = 8'd127
) (
    input  logic             clk,
    input  logic             reset,
    um2cdp_transmit_if.slave io
);

    in_state_t   in_state, in_state_nxt;
    out_state_t  out_state, out_state_nxt;
    logic        wr_req;
    pkt_word_t   wr_word;
    logic        trunc_q, trunc_nxt;
    logic        drop_inc;
    logic        wr_q;
    pkt_word_t   wr_dat_q;
    logic        rd_en;
    logic        data_vld_q;
    logic [7:0]  pkt_cnt;
    logic [15:0] drop_cnt_q;
    logic [8:0]  occ;
    logic        room;
    logic        tail_wr;
    logic        tail_rd;
    pkt_word_t   fifo_q;
    logic        fifo_mark;
    logic [7:0]  fifo_usedw;
    logic        fifo_full;

    // Count the word still in the write register so the buffer can never overflow.
    assign occ  = {fifo_full, fifo_usedw} + {8'd0, wr_q};
    assign room = (occ < 9'd256);

    always_comb begin
        in_state_nxt = in_state;
        wr_req       = 1'b0;
        wr_word      = io.pkt;
        trunc_nxt    = trunc_q;
        drop_inc     = 1'b0;
        unique case (in_state)
            IN_IDLE: begin
                if (io.pkt_valid && io.pkt.tag == TAG_HEAD) begin
                    if (!fifo_full && fifo_usedw <= ACCEPT_MAX && room) begin
                        wr_req       = 1'b1;
                        trunc_nxt    = 1'b0;
                        in_state_nxt = IN_STORE;
                    end else begin
                        drop_inc     = 1'b1;
                        in_state_nxt = IN_DROP;
                    end
                end
            end
            IN_STORE: begin
                if (io.pkt_valid) begin
                    if (!room) begin
                        trunc_nxt = 1'b1;
                    end else begin
                        wr_req = 1'b1;
                        // A repeated head or an earlier lost word closes the packet here.
                        if (trunc_q || io.pkt.tag == TAG_HEAD || io.pkt.tag == TAG_TAIL) begin
                            wr_word.tag  = TAG_TAIL;
                            trunc_nxt    = 1'b0;
                            in_state_nxt = IN_IDLE;
                        end
                    end
                end
            end
            IN_DROP: begin
                if (io.pkt_valid && io.pkt.tag == TAG_TAIL) in_state_nxt = IN_IDLE;
            end
            default: in_state_nxt = IN_IDLE;
        endcase
    end

    // The cycle after a tail read is spent re-evaluating, leaving one idle output cycle between packets.
    always_comb begin
        out_state_nxt = out_state;
        rd_en         = 1'b0;
        unique case (out_state)
            OUT_IDLE: begin
                if (pkt_cnt != 8'd0 && io.cdp2um_tx_enable && !data_vld_q) begin
                    rd_en = 1'b1;
                    if (!fifo_mark) out_state_nxt = OUT_SEND;
                end
            end
            OUT_SEND: begin
                rd_en = 1'b1;
                if (fifo_mark) out_state_nxt = OUT_IDLE;
            end
        endcase
    end

    assign tail_wr = wr_q && is_tail(wr_dat_q);
    assign tail_rd = rd_en && fifo_mark;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state   <= IN_IDLE;
            out_state  <= OUT_IDLE;
            trunc_q    <= 1'b0;
            wr_q       <= 1'b0;
            wr_dat_q   <= '0;
            data_vld_q <= 1'b0;
            pkt_cnt    <= 8'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            in_state   <= in_state_nxt;
            out_state  <= out_state_nxt;
            trunc_q    <= trunc_nxt;
            wr_q       <= wr_req;
            wr_dat_q   <= wr_word;
            data_vld_q <= rd_en;
            if (tail_wr && !tail_rd)      pkt_cnt <= pkt_cnt + 8'd1;
            else if (!tail_wr && tail_rd) pkt_cnt <= pkt_cnt - 8'd1;
            if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    um_sync_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_q),
        .wr_dat  (wr_dat_q),
        .wr_mark (is_tail(wr_dat_q)),
        .rd_en   (rd_en),
        .rd_dat  (fifo_q),
        .rd_mark (fifo_mark),
        .usedw   (fifo_usedw),
        .full    (fifo_full)
    );

    assign io.transmit_usedw    = fifo_usedw;
    assign io.um2cdp_data_valid = data_vld_q;
    assign io.um2cdp_data       = fifo_q;
    assign io.drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_um2cdp_transmit.sv
// Directed bench for um2cdp_transmit: drives packets, records every output word with its cycle, checks against hand-built words.
module tb_um2cdp_transmit;
    import um2cdp_transmit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    pkt_word_t out_q[$];
    int        out_t[$];

    always #5 clk = ~clk;

    um2cdp_transmit_if io();

    um2cdp_transmit #(.ACCEPT_MAX(8'd127)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io.um2cdp_data_valid) begin
            out_q.push_back(io.um2cdp_data);
            out_t.push_back(cyc);
        end
    end

    function automatic pkt_word_t mk(input logic [2:0] tag, input logic [31:0] id, input logic [31:0] idx);
        pkt_word_t w;
        w.tag     = tag;
        w.rsvd    = 8'h5A;
        w.payload = {id, 64'hC0DE_0000_FEED_0000, idx};
        return w;
    endfunction

    function automatic logic [2:0] tag_for(input int i, input int n);
        if (i == 0)     return TAG_HEAD;
        if (i == n - 1) return TAG_TAIL;
        return TAG_MID;
    endfunction

    task automatic chk_i(input string name, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic chk_w(input string name, input pkt_word_t obs, input pkt_word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [2:0] tag, input logic [31:0] id, input logic [31:0] idx);
        io.pkt_valid = 1'b1;
        io.pkt       = mk(tag, id, idx);
        step(1);
        io.pkt_valid = 1'b0;
    endtask

    // t_tail is the cycle count at which the tail word was put on the bus.
    task automatic send_pkt(input int n, input logic [31:0] id, output int t_tail);
        t_tail = 0;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) t_tail = cyc;
            send_word(tag_for(i, n), id, i);
        end
    endtask

    task automatic expect_pkt(input string name, input int base, input int n, input logic [31:0] id);
        pkt_word_t obs;
        for (int i = 0; i < n; i++) begin
            obs = (base + i < out_q.size()) ? out_q[base + i] : '0;
            chk_w($sformatf("%s_w%0d", name, i), obs, mk(tag_for(i, n), id, i));
        end
    endtask

    function automatic int t_at(input int i);
        return (i < out_t.size()) ? out_t[i] : -1000;
    endfunction

    initial begin
        int t_a;
        int t_b;
        int t_c;
        io.pkt_valid        = 1'b0;
        io.pkt              = '0;
        io.cdp2um_tx_enable = 1'b0;
        reset = 1'b0;
        step(3);
        chk_i("rst_valid", int'(io.um2cdp_data_valid), 0);
        chk_w("rst_data", io.um2cdp_data, '0);
        chk_i("rst_usedw", int'(io.transmit_usedw), 0);
        chk_i("rst_drop", int'(io.drop_cnt), 0);
        reset = 1'b1;
        step(2);

        // Headless words while idle vanish without counting as drops.
        send_word(TAG_MID, 100, 1);
        send_word(TAG_TAIL, 100, 2);
        step(4);
        chk_i("stray_drop", int'(io.drop_cnt), 0);
        chk_i("stray_usedw", int'(io.transmit_usedw), 0);
        chk_i("stray_out", out_q.size(), 0);

        // Single 4-word packet.
        io.cdp2um_tx_enable = 1'b1;
        send_pkt(4, 1, t_a);
        step(10);
        chk_i("p1_count", out_q.size(), 4);
        expect_pkt("p1", 0, 4, 1);
        chk_i("p1_latency", t_at(0) - t_a, 3);
        chk_i("p1_contig", t_at(3) - t_at(0), 3);
        chk_i("p1_drop", int'(io.drop_cnt), 0);
        chk_i("p1_usedw", int'(io.transmit_usedw), 0);

        // Two packets back to back on input.
        out_q.delete(); out_t.delete();
        send_pkt(4, 2, t_a);
        send_pkt(4, 3, t_b);
        step(15);
        chk_i("b2b_count", out_q.size(), 8);
        expect_pkt("b2b_a", 0, 4, 2);
        expect_pkt("b2b_b", 4, 4, 3);
        chk_i("b2b_latency", t_at(0) - t_a, 3);
        chk_i("b2b_a_contig", t_at(3) - t_at(0), 3);
        chk_i("b2b_gap", t_at(4) - t_at(3), 2);
        chk_i("b2b_b_contig", t_at(7) - t_at(4), 3);

        // Three packets parked, one-cycle enable releases exactly one.
        io.cdp2um_tx_enable = 1'b0;
        out_q.delete(); out_t.delete();
        send_pkt(4, 4, t_a);
        send_pkt(4, 5, t_b);
        send_pkt(4, 6, t_c);
        step(5);
        chk_i("park_out", out_q.size(), 0);
        chk_i("park_usedw", int'(io.transmit_usedw), 12);
        io.cdp2um_tx_enable = 1'b1;
        step(1);
        io.cdp2um_tx_enable = 1'b0;
        step(15);
        chk_i("pulse_count", out_q.size(), 4);
        expect_pkt("pulse", 0, 4, 4);
        chk_i("pulse_usedw", int'(io.transmit_usedw), 8);
        io.cdp2um_tx_enable = 1'b1;
        step(20);
        chk_i("rest_count", out_q.size(), 12);
        expect_pkt("rest5", 4, 4, 5);
        expect_pkt("rest6", 8, 4, 6);
        chk_i("rest_usedw", int'(io.transmit_usedw), 0);

        // Fill to 128 words; the next head is over the threshold and its packet is dropped.
        io.cdp2um_tx_enable = 1'b0;
        out_q.delete(); out_t.delete();
        send_pkt(64, 7, t_a);
        send_pkt(64, 8, t_b);
        step(3);
        chk_i("fill_usedw", int'(io.transmit_usedw), 128);
        send_pkt(4, 9, t_c);
        step(3);
        chk_i("fill_drop", int'(io.drop_cnt), 1);
        chk_i("fill_usedw_after", int'(io.transmit_usedw), 128);
        io.cdp2um_tx_enable = 1'b1;
        step(150);
        chk_i("drain_count", out_q.size(), 128);
        expect_pkt("drain7", 0, 64, 7);
        expect_pkt("drain8", 64, 64, 8);
        chk_i("drain_usedw", int'(io.transmit_usedw), 0);
        out_q.delete(); out_t.delete();
        send_pkt(4, 10, t_a);
        step(10);
        chk_i("after_drop_count", out_q.size(), 4);
        expect_pkt("after_drop", 0, 4, 10);

        // Head, middle, then a fresh head: the fresh head closes packet 11 as its tail.
        out_q.delete(); out_t.delete();
        send_word(TAG_HEAD, 11, 0);
        send_word(TAG_MID, 11, 1);
        send_word(TAG_HEAD, 12, 0);
        send_word(TAG_MID, 12, 1);
        send_word(TAG_TAIL, 12, 2);
        step(10);
        chk_i("trunc_count", out_q.size(), 3);
        chk_w("trunc_w0", (out_q.size() > 0) ? out_q[0] : '0, mk(TAG_HEAD, 11, 0));
        chk_w("trunc_w1", (out_q.size() > 1) ? out_q[1] : '0, mk(TAG_MID, 11, 1));
        chk_w("trunc_w2", (out_q.size() > 2) ? out_q[2] : '0, mk(TAG_TAIL, 12, 0));
        chk_i("trunc_drop", int'(io.drop_cnt), 1);
        chk_i("trunc_usedw", int'(io.transmit_usedw), 0);

        // Reset while the second word of a 6-word packet is on the output.
        out_q.delete(); out_t.delete();
        send_pkt(6, 13, t_a);
        step(3);
        chk_i("mid_valid", int'(io.um2cdp_data_valid), 1);
        chk_w("mid_word2", io.um2cdp_data, mk(TAG_MID, 13, 1));
        reset = 1'b0;
        step(1);
        chk_i("mid_rst_valid", int'(io.um2cdp_data_valid), 0);
        chk_i("mid_rst_usedw", int'(io.transmit_usedw), 0);
        chk_i("mid_rst_drop", int'(io.drop_cnt), 0);
        reset = 1'b1;
        step(2);
        out_q.delete(); out_t.delete();
        send_pkt(4, 14, t_a);
        step(10);
        chk_i("post_rst_count", out_q.size(), 4);
        expect_pkt("post_rst", 0, 4, 14);
        chk_i("post_rst_latency", t_at(0) - t_a, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
